spi_cmd_decoder: RTL and testbench

- Consumes 24-bit words from the SPI receive stage (`shiftreg` bus plus its `data_ready` level, already synchronised to `clk`).
- Decodes each word into a command:
  - WRITE loads a shadow register.
  - COMMIT copies all shadows to the active registers that drive the pulse generator.
  - CLEAR restores the active registers to defaults.
- Exactly one command is executed per `data_ready` assertion. Malformed commands are counted and flagged.

---
 rtl/spi_cmd_decoder_pkg.sv | 52 +++++
 rtl/spi_cmd_decoder.sv | 138 +++++++++++++
 tb/tb_spi_cmd_decoder.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/spi_cmd_decoder_pkg.sv
// rtl/spi_cmd_decoder_pkg.sv - opcode, address, field and FSM definitions for the SPI command decoder
package pulsar_spi_pkg;

    // Field positions inside a received 24-bit word
    localparam int OPC_HI  = 23;
    localparam int OPC_LO  = 20;
    localparam int ADDR_HI = 19;
    localparam int ADDR_LO = 16;
    localparam int DATA_HI = 15;
    localparam int DATA_LO = 0;

    localparam int NUM_REGS = 4;

    localparam logic [1:0] REG_PERIOD = 2'd0;
    localparam logic [1:0] REG_PWIDTH = 2'd1;
    localparam logic [1:0] REG_DELAY  = 2'd2;
    localparam logic [1:0] REG_CTRL   = 2'd3;

    typedef enum logic [3:0] {
        OP_WRITE  = 4'h1,
        OP_COMMIT = 4'h2,
        OP_CLEAR  = 4'h3
    } opcode_e;

    typedef enum logic [1:0] {
        CLS_WRITE,
        CLS_COMMIT,
        CLS_CLEAR,
        CLS_ILLEGAL
    } cmd_class_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DECODE,
        ST_APPLY,
        ST_WAIT_LOW
    } state_e;

    // Only four registers exist, so a WRITE is legal only when address bits [3:2] are zero
    function automatic cmd_class_e classify(input logic [3:0] opc, input logic [3:0] addr);
        cmd_class_e cls;
        cls = CLS_ILLEGAL;
        case (opc)
            OP_WRITE:  cls = (addr[3:2] == 2'b00) ? CLS_WRITE : CLS_ILLEGAL;
            OP_COMMIT: cls = CLS_COMMIT;
            OP_CLEAR:  cls = CLS_CLEAR;
            default:   cls = CLS_ILLEGAL;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/spi_cmd_decoder.sv
// rtl/spi_cmd_decoder.sv - decodes SPI words into shadow writes, commits and clears of the pulse registers
module spi_cmd_decoder
    import pulsar_spi_pkg::*;
#(
    parameter int                WIDTH      = 24,
    parameter int                DATA_W     = 16,
    parameter logic [DATA_W-1:0] DEF_PERIOD = 16'd1000,
    parameter logic [DATA_W-1:0] DEF_PWIDTH = 16'd100,
    parameter logic [DATA_W-1:0] DEF_DELAY  = 16'd0,
    parameter logic [DATA_W-1:0] DEF_CTRL   = 16'd0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WIDTH-1:0]  spi_word,
    input  logic              spi_data_ready,
    output logic [DATA_W-1:0] period,
    output logic [DATA_W-1:0] pulse_width,
    output logic [DATA_W-1:0] delay,
    output logic [DATA_W-1:0] ctrl,
    output logic              cfg_update,
    output logic              cmd_error,
    output logic [7:0]        err_count,
    output logic              busy
);

    state_e            state;
    state_e            state_n;
    logic [WIDTH-1:0]  cmd_q;
    cmd_class_e        cls_q;
    logic              do_capture;
    logic              do_decode;
    logic              do_apply;

    logic [DATA_W-1:0] shadow [NUM_REGS];
    logic [DATA_W-1:0] active [NUM_REGS];

    function automatic logic [DATA_W-1:0] def_val(input int idx);
        logic [DATA_W-1:0] v;
        case (idx)
            0:       v = DEF_PERIOD;
            1:       v = DEF_PWIDTH;
            2:       v = DEF_DELAY;
            default: v = DEF_CTRL;
        endcase
        return v;
    endfunction

    // WAIT_LOW absorbs the rest of the data_ready level so each word runs exactly once
    always_comb begin
        state_n    = state;
        do_capture = 1'b0;
        do_decode  = 1'b0;
        do_apply   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (spi_data_ready) begin
                    do_capture = 1'b1;
                    state_n    = ST_DECODE;
                end
            end
            ST_DECODE: begin
                do_decode = 1'b1;
                state_n   = ST_APPLY;
            end
            ST_APPLY: begin
                do_apply = 1'b1;
                state_n  = ST_WAIT_LOW;
            end
            ST_WAIT_LOW: begin
                if (!spi_data_ready) begin
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            cmd_q      <= '0;
            cls_q      <= CLS_ILLEGAL;
            cfg_update <= 1'b0;
            cmd_error  <= 1'b0;
            err_count  <= 8'd0;
            for (int i = 0; i < NUM_REGS; i++) begin
                shadow[i] <= def_val(i);
                active[i] <= def_val(i);
            end
        end else begin
            state      <= state_n;
            cfg_update <= 1'b0;
            cmd_error  <= 1'b0;

            if (do_capture) begin
                cmd_q <= spi_word;
            end

            if (do_decode) begin
                cls_q <= classify(cmd_q[OPC_HI:OPC_LO], cmd_q[ADDR_HI:ADDR_LO]);
            end

            if (do_apply) begin
                case (cls_q)
                    CLS_WRITE: begin
                        shadow[cmd_q[ADDR_LO+1:ADDR_LO]] <= cmd_q[DATA_HI:DATA_LO];
                    end
                    CLS_COMMIT: begin
                        for (int i = 0; i < NUM_REGS; i++) begin
                            active[i] <= shadow[i];
                        end
                        cfg_update <= 1'b1;
                    end
                    CLS_CLEAR: begin
                        for (int i = 0; i < NUM_REGS; i++) begin
                            shadow[i] <= def_val(i);
                            active[i] <= def_val(i);
                        end
                        cfg_update <= 1'b1;
                    end
                    default: begin
                        cmd_error <= 1'b1;
                        if (err_count != 8'hFF) begin
                            err_count <= err_count + 8'd1;
                        end
                    end
                endcase
            end
        end
    end

    assign period      = active[REG_PERIOD];
    assign pulse_width = active[REG_PWIDTH];
    assign delay       = active[REG_DELAY];
    assign ctrl        = active[REG_CTRL];
    assign busy        = (state != ST_IDLE);

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// tb/tb_spi_cmd_decoder.sv - scoreboard bench for spi_cmd_decoder
module tb_spi_cmd_decoder;

    typedef struct packed {
        logic [15:0] period;
        logic [15:0] pwidth;
        logic [15:0] delay;
        logic [15:0] ctrl;
        logic        cfg;
        logic        err;
        logic [7:0]  cnt;
    } obs_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [23:0] spi_word;
    logic        spi_data_ready;
    logic [15:0] period;
    logic [15:0] pulse_width;
    logic [15:0] delay;
    logic [15:0] ctrl;
    logic        cfg_update;
    logic        cmd_error;
    logic [7:0]  err_count;
    logic        busy;

    int vectors     = 0;
    int miscompares = 0;

    obs_t        exp_q[$];
    logic [15:0] m_sh  [4];
    logic [15:0] m_act [4];
    logic [7:0]  m_cnt;

    spi_cmd_decoder dut (
        .clk            (clk),
        .reset          (reset),
        .spi_word       (spi_word),
        .spi_data_ready (spi_data_ready),
        .period         (period),
        .pulse_width    (pulse_width),
        .delay          (delay),
        .ctrl           (ctrl),
        .cfg_update     (cfg_update),
        .cmd_error      (cmd_error),
        .err_count      (err_count),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] def_of(input int i);
        logic [15:0] v;
        case (i)
            0:       v = 16'd1000;
            1:       v = 16'd100;
            default: v = 16'd0;
        endcase
        return v;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) begin
            m_sh[i]  = def_of(i);
            m_act[i] = def_of(i);
        end
        m_cnt = 8'd0;
    endfunction

    function automatic obs_t model_state(input logic cfg, input logic err);
        return {m_act[0], m_act[1], m_act[2], m_act[3], cfg, err, m_cnt};
    endfunction

    function automatic obs_t model_apply(input logic [23:0] w);
        logic [3:0]  op;
        logic [3:0]  a;
        logic        cfg;
        logic        err;
        op  = w[23:20];
        a   = w[19:16];
        cfg = 1'b0;
        err = 1'b0;
        if (op == 4'h1 && a < 4'd4) begin
            m_sh[a[1:0]] = w[15:0];
        end else if (op == 4'h2) begin
            for (int i = 0; i < 4; i++) m_act[i] = m_sh[i];
            cfg = 1'b1;
        end else if (op == 4'h3) begin
            for (int i = 0; i < 4; i++) begin
                m_sh[i]  = def_of(i);
                m_act[i] = def_of(i);
            end
            cfg = 1'b1;
        end else begin
            err = 1'b1;
            if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
        end
        return model_state(cfg, err);
    endfunction

    function automatic obs_t sample();
        return {period, pulse_width, delay, ctrl, cfg_update, cmd_error, err_count};
    endfunction

    task automatic chk_obs(input string tag, input obs_t got, input obs_t exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int got, input int exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drive one word and keep data_ready high for 'hold' cycles after capture
    task automatic send(input string tag, input logic [23:0] w, input int hold);
        obs_t prev;
        obs_t e;
        int   pulses;
        prev = model_state(1'b0, 1'b0);
        exp_q.push_back(model_apply(w));
        @(negedge clk);
        spi_word       = w;
        spi_data_ready = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            if (i >= hold) begin
                spi_data_ready = 1'b0;
                spi_word       = 24'hFFFFFF;
            end
            if (i == 2) chk_obs({tag, "_early"}, sample(), prev);
        end
        if (exp_q.size() == 0) begin
            chk_int({tag, "_queue"}, 0, 1);
        end else begin
            e = exp_q.pop_front();
            chk_obs(tag, sample(), e);
        end
        chk_int({tag, "_busy_hi"}, int'(busy), 1);
        pulses = 0;
        for (int i = 4; i <= hold; i++) begin
            @(negedge clk);
            if (cfg_update || cmd_error) pulses++;
        end
        if (hold > 3) begin
            chk_int({tag, "_extra_pulses"}, pulses, 0);
            spi_data_ready = 1'b0;
        end
        @(negedge clk);
        chk_int({tag, "_busy_lo"}, int'(busy), 0);
    endtask

    initial begin
        logic [3:0] op;
        reset          = 1'b1;
        spi_word       = 24'h0;
        spi_data_ready = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk_obs("reset_regs", sample(), model_state(1'b0, 1'b0));
        chk_int("reset_busy", int'(busy), 0);

        send("write_period",  24'h1001F4, 4);
        send("commit_period", 24'h200000, 4);

        send("write_held",    24'h110200, 20);
        send("write_again",   24'h110200, 4);
        send("commit_pw",     24'h200000, 4);

        send("illegal_addr",  24'h170005, 20);
        send("illegal_op",    24'hF00000, 3);

        send("write_delay",   24'h120007, 2);
        send("commit_short",  24'h200000, 1);

        for (int n = 0; n < 300; n++) begin
            op = 4'($urandom_range(3, 15));
            if (op == 4'h3) op = 4'h0;
            send("illegal_sat", {op, 4'($urandom_range(0, 15)), 16'($urandom)}, 2);
        end
        chk_int("err_saturated", int'(err_count), 255);

        send("write_ctrl",    24'h130001, 4);
        send("commit_ctrl",   24'h200000, 4);
        send("clear",         24'h300000, 4);
        send("commit_after_clear", 24'h200000, 4);

        send("write_pre_rst", 24'h100309, 4);
        @(negedge clk);
        spi_word       = 24'h200000;
        spi_data_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset          = 1'b1;
        spi_data_ready = 1'b0;
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        chk_obs("reset_in_apply", sample(), model_state(1'b0, 1'b0));
        chk_int("reset_in_apply_busy", int'(busy), 0);
        @(negedge clk);
        chk_obs("after_reset", sample(), model_state(1'b0, 1'b0));

        send("commit_post_rst", 24'h200000, 4);
        send("write_post_rst",  24'h10ABCD, 4);
        send("commit_final",    24'h200000, 4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
